uart_tx_arbiter: RTL and testbench

Round-robin packet arbiter that shares the single UART transmit path (TX FIFO write port `wr_uart`/`w_data`, flow-controlled by `tx_full`) between `N_REQ` byte-stream requesters. A requester owns the transmitter from the first byte of a packet until its `last` byte is accepted, so packets never interleave on the serial line. It sits between the application sources (text generator, status reporter, debug echo) and the `uart` wrapper's transmit side. An idle-timeout releases an owner that stalls mid-packet.

---
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART TX FIFO write port
// among N_REQ byte-stream requesters, holding ownership from first byte to last.
// Latency: grant one cycle after req in IDLE; bytes then pass combinationally.
// Backpressure: i_tx_full blocks writes and acks in the same cycle and never
// counts toward the idle timeout; only an owner with req low can time out.
//
// Ports:
//   i_clk, i_reset      clock and synchronous active-high reset
//   i_req[N]            requester i has a byte on lane i
//   i_req_data[8N]      lane i = bits [8i+7:8i]
//   i_req_last[N]       lane i byte ends its packet
//   o_req_ack[N]        one-hot pop strobe, byte of owner written this cycle
//   i_tx_full           TX FIFO full
//   o_wr_uart, o_w_data TX FIFO write strobe and data
//   o_grant[N]          one-hot registered owner, zero when idle
//   o_busy              registered, high in SEND
//   o_abort             registered one-cycle pulse on idle timeout
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ack,
  input  logic               i_tx_full,
  output logic               o_wr_uart,
  output logic [7:0]         o_w_data,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_abort
);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last_owner;
  logic [TO_W-1:0]    r_to_cnt;
  logic [N_REQ-1:0]   r_grant;
  logic               r_busy;
  logic               r_abort;

  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_owner_req;
  logic               w_owner_last;
  logic [7:0]         w_owner_data;
  logic               w_xfer;

  // Round-robin search starting just after the previous owner. The loop runs
  // from the farthest candidate down to the nearest so that the nearest
  // asserted requester is the last assignment and therefore wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = r_last_owner;
    for (int d = N_REQ; d >= 1; d--) begin
      logic [IDX_W-1:0] w_cand;
      w_cand = IDX_W'((int'(r_last_owner) + d) % N_REQ);
      if (i_req[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  assign w_owner_req  = i_req[r_owner];
  assign w_owner_last = i_req_last[r_owner];
  assign w_owner_data = i_req_data[{r_owner, 3'b000} +: 8];
  assign w_xfer       = (r_state == ST_SEND) && w_owner_req && !i_tx_full;

  // Write path is combinational so a full FIFO stops the write in the same cycle.
  assign o_wr_uart = w_xfer;
  assign o_req_ack = w_xfer ? (N_REQ'(1) << r_owner) : '0;
  assign o_w_data  = (r_state == ST_SEND) ? w_owner_data : 8'h00;

  assign o_grant = r_grant;
  assign o_busy  = r_busy;
  assign o_abort = r_abort;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(N_REQ - 1);
      r_to_cnt     <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_owner  <= w_pick_idx;
            r_grant  <= N_REQ'(1) << w_pick_idx;
            r_busy   <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_to_cnt <= '0;
            if (w_owner_last) begin
              r_last_owner <= r_owner;
              r_grant      <= '0;
              r_busy       <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end else if (!w_owner_req) begin
            // Only an absent owner ages; a stalled-by-full owner holds the count.
            if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
              r_abort      <= 1'b1;
              r_last_owner <= r_owner;
              r_grant      <= '0;
              r_busy       <= 1'b0;
              r_to_cnt     <= '0;
              r_state      <= ST_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (TIMEOUT 4 and 8) share all inputs.
// Directed vectors from a table, hand sequences for multi-cycle corners, then
// random traffic compared every cycle against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TO0 = 4;
  localparam int TO1 = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  last;
  logic        full;

  logic [3:0]  ack   [2];
  logic [3:0]  grant [2];
  logic        wr    [2];
  logic [7:0]  wd    [2];
  logic        busy  [2];
  logic        abort [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .IDX_W(2), .TIMEOUT(TO0), .TO_W(3)) u_dut4 (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_data(data), .i_req_last(last),
    .o_req_ack(ack[0]), .i_tx_full(full), .o_wr_uart(wr[0]), .o_w_data(wd[0]),
    .o_grant(grant[0]), .o_busy(busy[0]), .o_abort(abort[0]));

  uart_tx_arbiter #(.N_REQ(N), .IDX_W(2), .TIMEOUT(TO1), .TO_W(4)) u_dut8 (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_data(data), .i_req_last(last),
    .o_req_ack(ack[1]), .i_tx_full(full), .o_wr_uart(wr[1]), .o_w_data(wd[1]),
    .o_grant(grant[1]), .o_busy(busy[1]), .o_abort(abort[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packet-level view: who owns the line, who went last, and how many
  // consecutive cycles the owner has been absent.
  bit mdl_on = 1'b0;
  bit m_busy   [2] = '{1'b0, 1'b0};
  int m_owner  [2] = '{0, 0};
  int m_lastown[2] = '{N - 1, N - 1};
  int m_absent [2] = '{0, 0};
  bit m_abort  [2] = '{1'b0, 1'b0};
  int mdl_tov;
  int mdl_c;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mdl_tov = (k == 0) ? TO0 : TO1;
      if (reset) begin
        m_busy[k] = 1'b0; m_owner[k] = 0; m_lastown[k] = N - 1;
        m_absent[k] = 0;  m_abort[k] = 1'b0;
      end else begin
        m_abort[k] = 1'b0;
        if (!m_busy[k]) begin
          for (int d = 1; d <= N; d++) begin
            mdl_c = (m_lastown[k] + d) % N;
            if (req[mdl_c]) begin
              m_owner[k] = mdl_c; m_busy[k] = 1'b1; m_absent[k] = 0;
              break;
            end
          end
        end else if (req[m_owner[k]]) begin
          if (!full) begin
            m_absent[k] = 0;
            if (last[m_owner[k]]) begin
              m_busy[k] = 1'b0; m_lastown[k] = m_owner[k];
            end
          end
        end else begin
          m_absent[k] = m_absent[k] + 1;
          if (m_absent[k] == mdl_tov) begin
            m_abort[k] = 1'b1; m_busy[k] = 1'b0; m_lastown[k] = m_owner[k];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] e_grant;
        logic       e_xfer;
        logic [7:0] e_wd;
        e_grant = m_busy[k] ? 4'(1 << m_owner[k]) : 4'h0;
        e_xfer  = m_busy[k] && req[m_owner[k]] && !full;
        e_wd    = m_busy[k] ? data[8*m_owner[k] +: 8] : 8'h00;
        chk($sformatf("m%0d_grant", k), 32'(grant[k]), 32'(e_grant));
        chk($sformatf("m%0d_busy",  k), 32'(busy[k]),  32'(m_busy[k]));
        chk($sformatf("m%0d_abort", k), 32'(abort[k]), 32'(m_abort[k]));
        chk($sformatf("m%0d_wr",    k), 32'(wr[k]),    32'(e_xfer));
        chk($sformatf("m%0d_wdata", k), 32'(wd[k]),    32'(e_wd));
        chk($sformatf("m%0d_ack",   k), 32'(ack[k]),   e_xfer ? 32'(1 << m_owner[k]) : 32'h0);
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_wr;
    logic [7:0]  e_wd;
    logic [3:0]  e_ack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic [3:0] rq, logic [31:0] dt, logic [3:0] ls,
                             logic fl, logic [3:0] g, logic b, logic w, logic [7:0] d,
                             logic [3:0] a);
    vec_t r;
    r.rst = rst; r.req = rq; r.data = dt; r.last = ls; r.full = fl;
    r.e_grant = g; r.e_busy = b; r.e_wr = w; r.e_wd = d; r.e_ack = a;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] rq, input logic [31:0] dt,
                       input logic [3:0] ls, input logic fl);
    reset = rst; req = rq; data = dt; last = ls; full = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
    // Single requester, three-byte packet
    tbl.push_back(v(1, 4'h0, 32'h0,  4'h0, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'h1, 32'h41, 4'h0, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'h1, 32'h41, 4'h0, 0, 4'h1, 1, 1, 8'h41, 4'h1));
    tbl.push_back(v(0, 4'h1, 32'h42, 4'h0, 0, 4'h1, 1, 1, 8'h42, 4'h1));
    tbl.push_back(v(0, 4'h1, 32'h43, 4'h1, 0, 4'h1, 1, 1, 8'h43, 4'h1));
    tbl.push_back(v(0, 4'h0, 32'h0,  4'h0, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    // Round-robin with four single-byte requesters
    tbl.push_back(v(1, 4'h0, 32'h0,        4'h0, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h1, 1, 1, 8'h10, 4'h1));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h2, 1, 1, 8'h11, 4'h2));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h4, 1, 1, 8'h12, 4'h4));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h8, 1, 1, 8'h13, 4'h8));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h1, 1, 1, 8'h10, 4'h1));
    tbl.push_back(v(0, 4'h0, 32'h0,        4'h0, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    // Backpressure: five full cycles mid-packet, longer than TIMEOUT=4
    tbl.push_back(v(0, 4'h2, 32'h5500, 4'h0, 0, 4'h0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(v(0, 4'h2, 32'h5500, 4'h0, 0, 4'h2, 1, 1, 8'h55, 4'h2));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 4'h2, 32'h5600, 4'h0, 1, 4'h2, 1, 0, 8'h56, 4'h0));
    tbl.push_back(v(0, 4'h2, 32'h5600, 4'h2, 0, 4'h2, 1, 1, 8'h56, 4'h2));
    tbl.push_back(v(0, 4'h0, 32'h0,    4'h0, 0, 4'h0, 0, 0, 8'h00, 4'h0));

    repeat (2) @(posedge clk);
    #1;
    mdl_on = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].data, tbl[i].last, tbl[i].full);
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), 32'(grant[0]), 32'(tbl[i].e_grant));
      chk($sformatf("v%0d_busy",  i), 32'(busy[0]),  32'(tbl[i].e_busy));
      chk($sformatf("v%0d_abort", i), 32'(abort[0]), 32'h0);
      chk($sformatf("v%0d_wr",    i), 32'(wr[0]),    32'(tbl[i].e_wr));
      chk($sformatf("v%0d_wdata", i), 32'(wd[0]),    32'(tbl[i].e_wd));
      chk($sformatf("v%0d_ack",   i), 32'(ack[0]),   32'(tbl[i].e_ack));
      tick();
    end

    // Timeout: requester 2 sends one byte then vanishes; 0 and 3 wait.
    drive(0, 4'b0100, 32'h0077_0000, 4'h0, 0);
    tick();
    @(negedge clk);
    chk("to_grant_first", 32'(grant[1]), 32'h4);
    chk("to_wr_first", 32'(wr[1]), 32'h1);
    tick();
    for (int i = 0; i < TO1; i++) begin
      drive(0, 4'b1001, 32'h0, 4'h0, 0);
      @(negedge clk);
      chk("to8_no_abort_yet", 32'(abort[1]), 32'h0);
      chk("to8_grant_held", 32'(grant[1]), 32'h4);
      if (i == TO0) begin
        chk("to4_abort", 32'(abort[0]), 32'h1);
        chk("to4_grant_clear", 32'(grant[0]), 32'h0);
      end
      tick();
    end
    @(negedge clk);
    chk("to8_abort", 32'(abort[1]), 32'h1);
    chk("to8_grant_clear", 32'(grant[1]), 32'h0);
    chk("to8_busy_clear", 32'(busy[1]), 32'h0);
    tick();
    @(negedge clk);
    chk("to8_next_owner3", 32'(grant[1]), 32'h8);
    chk("to8_abort_single", 32'(abort[1]), 32'h0);
    tick();
    drive(1, 4'h0, 32'h0, 4'h0, 0);
    tick();

    // No interleaving: requester 1 arrives while requester 2 is mid-packet.
    drive(0, 4'b0100, 32'h00A0_0000, 4'h0, 0);
    tick();
    @(negedge clk);
    chk("ni_grant2", 32'(grant[0]), 32'h4);
    chk("ni_b0", 32'(wd[0]), 32'hA0);
    tick();
    drive(0, 4'b0100, 32'h00A1_0000, 4'h0, 0);
    @(negedge clk);
    chk("ni_b1", 32'(wd[0]), 32'hA1);
    tick();
    drive(0, 4'b0110, 32'h00A2_B000, 4'h0, 0);
    @(negedge clk);
    chk("ni_hold_grant", 32'(grant[0]), 32'h4);
    chk("ni_b2", 32'(wd[0]), 32'hA2);
    chk("ni_ack2", 32'(ack[0]), 32'h4);
    tick();
    drive(0, 4'b0110, 32'h00A3_B000, 4'b0100, 0);
    @(negedge clk);
    chk("ni_b3", 32'(wd[0]), 32'hA3);
    chk("ni_ack3", 32'(ack[0]), 32'h4);
    tick();
    drive(0, 4'b0010, 32'h0000_B000, 4'b0010, 0);
    @(negedge clk);
    chk("ni_bubble", 32'(grant[0]), 32'h0);
    tick();
    @(negedge clk);
    chk("ni_grant1", 32'(grant[0]), 32'h2);
    chk("ni_r1_byte", 32'(wd[0]), 32'hB0);
    chk("ni_r1_ack", 32'(ack[0]), 32'h2);
    tick();
    drive(0, 4'h0, 32'h0, 4'h0, 0);
    tick();

    // Reset during byte 2 of requester 3's packet; requester 0 then wins.
    drive(0, 4'b1000, 32'hC000_0000, 4'h0, 0);
    tick();
    @(negedge clk);
    chk("rst_grant3", 32'(grant[0]), 32'h8);
    tick();
    drive(1, 4'b1000, 32'hC100_0000, 4'h0, 0);
    tick();
    drive(0, 4'b1001, 32'hC100_00D0, 4'h0, 0);
    @(negedge clk);
    chk("rst_grant", 32'(grant[0]), 32'h0);
    chk("rst_wr", 32'(wr[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_ack", 32'(ack[0]), 32'h0);
    tick();
    @(negedge clk);
    chk("rst_prio0", 32'(grant[0]), 32'h1);
    chk("rst_prio0_data", 32'(wd[0]), 32'hD0);
    tick();

    // Random traffic in bursts of varying density; the model checks each cycle.
    for (int blk = 0; blk < 60; blk++) begin
      int p;
      case ($urandom_range(2))
        0:       p = 90;
        1:       p = 50;
        default: p = 10;
      endcase
      for (int c = 0; c < 50; c++) begin
        logic [3:0] rq, ls;
        for (int b = 0; b < N; b++) begin
          rq[b] = ($urandom_range(99) < p);
          ls[b] = ($urandom_range(99) < 25);
        end
        drive(($urandom_range(999) == 0), rq, $urandom, ls, ($urandom_range(99) < 30));
        tick();
      end
    end

    @(negedge clk);
    mdl_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
